// File: rtl/exe_mem_sram_pkg.sv
// exe_mem_sram_pkg: shared constants and FSM state encoding for the memory stage
package exe_mem_sram_pkg;
  localparam logic RAM_ENABLE   = 1'b1;
  localparam logic RAM_DISABLE  = 1'b0;
  localparam logic RAM_OP_RD    = 1'b0;
  localparam logic RAM_OP_WR    = 1'b1;
  localparam logic PAUSE_ENABLE = 1'b1;
  localparam int REG_OP_W = 2;
  localparam logic [REG_OP_W-1:0] REG_OP_NOP = '0;
  typedef enum logic [2:0] {
    EM_ST_IDLE     = 3'd0,
    EM_ST_RD       = 3'd1,
    EM_ST_WR_SETUP = 3'd2,
    EM_ST_WR_PULSE = 3'd3,
    EM_ST_WR_HOLD  = 3'd4
  } em_state_e;
endpackage

// File: rtl/exe_mem_sram_sram_if_fsm.sv
// sram_if_fsm: SRAM access sequencer owning state, wait counter, registered strobes and bus enable
// Ports: clk_50MHz/rst (async active-low); start/wr begin a read or write access from IDLE;
// idle/done report the sequencer position; ce_n/oe_n/we_n/data_oe are registered SRAM controls.
module sram_if_fsm import exe_mem_sram_pkg::*; #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic start,
  input  logic wr,
  output logic idle,
  output logic done,
  output logic ce_n,
  output logic oe_n,
  output logic we_n,
  output logic data_oe
);
  localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES);
  em_state_e st, st_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic cnt_last;
  assign cnt_last = cnt == WAIT_LAST;
  assign idle = st == EM_ST_IDLE;
  assign done = (st == EM_ST_RD && cnt_last) || st == EM_ST_WR_HOLD;
  // Strobes are decoded from the next state and registered, so they switch cleanly with the state.
  always_ff @(posedge clk_50MHz or negedge rst)
    if (!rst) begin
      st      <= EM_ST_IDLE;
      cnt     <= '0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      data_oe <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      ce_n    <= st_nxt == EM_ST_IDLE;
      oe_n    <= st_nxt != EM_ST_RD;
      we_n    <= st_nxt != EM_ST_WR_PULSE;
      data_oe <= st_nxt inside {EM_ST_WR_SETUP, EM_ST_WR_PULSE, EM_ST_WR_HOLD};
    end
  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    case (st)
      EM_ST_IDLE:     st_nxt = start ? (wr ? EM_ST_WR_SETUP : EM_ST_RD) : EM_ST_IDLE;
      EM_ST_RD:       begin
        st_nxt  = cnt_last ? EM_ST_IDLE : EM_ST_RD;
        cnt_nxt = cnt_last ? 2'd0 : cnt + 2'd1;
      end
      EM_ST_WR_SETUP: st_nxt = EM_ST_WR_PULSE;
      EM_ST_WR_PULSE: begin
        st_nxt  = cnt_last ? EM_ST_WR_HOLD : EM_ST_WR_PULSE;
        cnt_nxt = cnt_last ? 2'd0 : cnt + 2'd1;
      end
      EM_ST_WR_HOLD:  st_nxt = EM_ST_IDLE;
      default:        st_nxt = EM_ST_IDLE;
    endcase
  end
endmodule

// File: rtl/exe_mem_sram.sv
// exe_mem_sram: memory stage latching EXE results and running multi-cycle SRAM loads/stores
// Ports: clk_50MHz/rst (async active-low); n_em_* EXE-stage instruction fields;
// em_PAUSE stalls upstream during an access; mw_* write-back op/addr/data to WB;
// ram_addr/ram_data/ram_ce_n/ram_oe_n/ram_we_n drive the external 16-bit SRAM.
module exe_mem_sram import exe_mem_sram_pkg::*; #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic                n_em_RAM_en,
  input  logic                n_em_RAM_op,
  input  logic [15:0]         n_em_ADDR,
  input  logic [15:0]         n_em_WDATA,
  input  logic [15:0]         n_em_WB_DATA,
  input  logic [REG_OP_W-1:0] n_em_REG_op,
  input  logic [3:0]          n_em_WB_ADDR,
  output logic                em_PAUSE,
  output logic [REG_OP_W-1:0] mw_REG_op,
  output logic [3:0]          mw_WB_ADDR,
  output logic [15:0]         mw_WB_DATA,
  output logic [17:0]         ram_addr,
  inout  wire  [15:0]         ram_data,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n
);
  logic idle, done, start, data_oe, op_q;
  logic [15:0] addr_q, wdata_q;
  logic [REG_OP_W-1:0] reg_op_q;
  logic [3:0] wb_addr_q;
  assign start    = idle && n_em_RAM_en == RAM_ENABLE;
  assign ram_addr = {2'b00, addr_q};
  assign ram_data = data_oe ? wdata_q : 16'bz;
  sram_if_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .start     (start),
    .wr        (n_em_RAM_op == RAM_OP_WR),
    .idle      (idle),
    .done      (done),
    .ce_n      (ram_ce_n),
    .oe_n      (ram_oe_n),
    .we_n      (ram_we_n),
    .data_oe   (data_oe)
  );
  // mw_REG_op is forced to NOP on every busy edge except completion so WB writes exactly once.
  always_ff @(posedge clk_50MHz or negedge rst)
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      reg_op_q   <= REG_OP_NOP;
      wb_addr_q  <= '0;
      op_q       <= RAM_OP_RD;
      em_PAUSE   <= ~PAUSE_ENABLE;
      mw_REG_op  <= REG_OP_NOP;
      mw_WB_ADDR <= '0;
      mw_WB_DATA <= '0;
    end else if (start) begin
      addr_q    <= n_em_ADDR;
      wdata_q   <= n_em_WDATA;
      reg_op_q  <= n_em_REG_op;
      wb_addr_q <= n_em_WB_ADDR;
      op_q      <= n_em_RAM_op;
      mw_REG_op <= REG_OP_NOP;
      em_PAUSE  <= PAUSE_ENABLE;
    end else if (idle) begin
      mw_REG_op  <= n_em_REG_op;
      mw_WB_ADDR <= n_em_WB_ADDR;
      mw_WB_DATA <= n_em_WB_DATA;
      em_PAUSE   <= ~PAUSE_ENABLE;
    end else if (done) begin
      mw_REG_op  <= reg_op_q;
      mw_WB_ADDR <= wb_addr_q;
      mw_WB_DATA <= op_q == RAM_OP_RD ? ram_data : mw_WB_DATA;
      em_PAUSE   <= ~PAUSE_ENABLE;
    end else
      mw_REG_op <= REG_OP_NOP;
endmodule

// File: tb/tb_exe_mem_sram.sv
// tb_exe_mem_sram: randomized transaction-level check of exe_mem_sram against a memory/latency model
module tb_exe_mem_sram;
  import exe_mem_sram_pkg::*;
  localparam int W = 1;
  logic clk_50MHz = 1'b0;
  logic rst = 1'b0;
  logic n_em_RAM_en = 1'b0, n_em_RAM_op = 1'b0;
  logic [15:0] n_em_ADDR = '0, n_em_WDATA = '0, n_em_WB_DATA = '0;
  logic [REG_OP_W-1:0] n_em_REG_op = '0;
  logic [3:0] n_em_WB_ADDR = '0;
  logic em_PAUSE;
  logic [REG_OP_W-1:0] mw_REG_op;
  logic [3:0] mw_WB_ADDR;
  logic [15:0] mw_WB_DATA;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic ram_ce_n, ram_oe_n, ram_we_n;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [int];
  int n_cmp = 0, n_bad = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  exe_mem_sram #(.WAIT_CYCLES(W)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .n_em_RAM_en(n_em_RAM_en), .n_em_RAM_op(n_em_RAM_op),
    .n_em_ADDR(n_em_ADDR), .n_em_WDATA(n_em_WDATA), .n_em_WB_DATA(n_em_WB_DATA),
    .n_em_REG_op(n_em_REG_op), .n_em_WB_ADDR(n_em_WB_ADDR), .em_PAUSE(em_PAUSE),
    .mw_REG_op(mw_REG_op), .mw_WB_ADDR(mw_WB_ADDR), .mw_WB_DATA(mw_WB_DATA),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  // Asynchronous SRAM device: drives on a read, captures writes while we_n is low.
  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr[15:0]] : 16'bz;
  always @(negedge clk_50MHz)
    if (rst && !ram_ce_n && !ram_we_n) mem[ram_addr[15:0]] <= ram_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic issue(input logic en, input logic op, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] wb, input logic [REG_OP_W-1:0] ro, input logic [3:0] wa);
    int pc, oe, we, ce, drv, nn;
    logic [15:0] exp;
    pc = 0; oe = 0; we = 0; ce = 0; drv = 0; nn = 0;
    @(negedge clk_50MHz);
    n_em_RAM_en = en; n_em_RAM_op = op; n_em_ADDR = a; n_em_WDATA = wd;
    n_em_WB_DATA = wb; n_em_REG_op = ro; n_em_WB_ADDR = wa;
    @(posedge clk_50MHz); #1;
    if (en != RAM_ENABLE) begin
      chk("pt_data", 32'(mw_WB_DATA), 32'(wb));
      chk("pt_addr", 32'(mw_WB_ADDR), 32'(wa));
      chk("pt_op", 32'(mw_REG_op), 32'(ro));
      chk("pt_pause", 32'(em_PAUSE), 32'd0);
      return;
    end
    exp = ref_rd(a);
    chk("cap_pause", 32'(em_PAUSE), 32'd1);
    chk("cap_bubble", 32'(mw_REG_op), 32'(REG_OP_NOP));
    chk("ram_addr", 32'(ram_addr), {16'h0, a});
    while (em_PAUSE === 1'b1 && pc < 20) begin
      pc++;
      if (!ram_oe_n) oe++;
      if (!ram_we_n) we++;
      if (!ram_ce_n) ce++;
      if (op == RAM_OP_WR && ram_data === wd) drv++;
      if (mw_REG_op != REG_OP_NOP) nn++;
      n_em_RAM_en = 1'($urandom); n_em_RAM_op = 1'($urandom); n_em_ADDR = 16'($urandom);
      n_em_WDATA = 16'($urandom); n_em_WB_DATA = 16'($urandom);
      n_em_REG_op = REG_OP_W'($urandom); n_em_WB_ADDR = 4'($urandom);
      @(posedge clk_50MHz); #1;
    end
    if (pc >= 20) chk("timeout", 32'd1, 32'd0);
    chk("busy_ce", 32'(ce), 32'(pc));
    chk("busy_nonnop", 32'(nn), 32'd0);
    chk("done_op", 32'(mw_REG_op), 32'(ro));
    chk("done_waddr", 32'(mw_WB_ADDR), 32'(wa));
    if (op == RAM_OP_RD) begin
      chk("ld_pause", 32'(pc), 32'(1 + W));
      chk("ld_oe", 32'(oe), 32'(1 + W));
      chk("ld_we", 32'(we), 32'd0);
      chk("ld_data", 32'(mw_WB_DATA), 32'(exp));
    end else begin
      ref_mem[int'(a)] = wd;
      chk("st_pause", 32'(pc), 32'(3 + W));
      chk("st_we", 32'(we), 32'(1 + W));
      chk("st_oe", 32'(oe), 32'd0);
      chk("st_drive", 32'(drv), 32'(3 + W));
      chk("st_mem", 32'(mem[a]), 32'(wd));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h8000] = 16'hBEEF;
    ref_mem[int'(16'h8000)] = 16'hBEEF;
    repeat (2) @(posedge clk_50MHz);
    #1;
    chk("rst_pause", 32'(em_PAUSE), 32'd0);
    chk("rst_op", 32'(mw_REG_op), 32'(REG_OP_NOP));
    chk("rst_wbdata", 32'(mw_WB_DATA), 32'd0);
    chk("rst_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    @(negedge clk_50MHz) rst = 1'b1;
    issue(RAM_DISABLE, RAM_OP_RD, 16'h0, 16'h0, 16'h1234, 2'd1, 4'd3);
    @(posedge clk_50MHz); #3;
    rst = 1'b0;
    #1;
    chk("arst_op", 32'(mw_REG_op), 32'(REG_OP_NOP));
    chk("arst_waddr", 32'(mw_WB_ADDR), 32'd0);
    chk("arst_wbdata", 32'(mw_WB_DATA), 32'd0);
    chk("arst_addr", 32'(ram_addr), 32'd0);
    chk("arst_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    @(negedge clk_50MHz) rst = 1'b1;
    issue(RAM_ENABLE, RAM_OP_RD, 16'h8000, 16'h0, 16'h0, 2'd2, 4'd5);
    issue(RAM_ENABLE, RAM_OP_WR, 16'h0010, 16'h5A5A, 16'h0, REG_OP_NOP, 4'd0);
    issue(RAM_ENABLE, RAM_OP_RD, 16'h0010, 16'h0, 16'h0, 2'd1, 4'd7);
    for (int i = 0; i < 60; i++)
      issue(1'($urandom), 1'($urandom), 16'($urandom_range(0, 7)) * 16'h1111,
            16'($urandom) | 16'h0001, 16'($urandom), REG_OP_W'($urandom), 4'($urandom));
    @(negedge clk_50MHz);
    n_em_RAM_en = RAM_ENABLE; n_em_RAM_op = RAM_OP_WR; n_em_ADDR = 16'h0020;
    n_em_WDATA = 16'hC3C3; n_em_REG_op = 2'd3; n_em_WB_ADDR = 4'd9;
    repeat (2) @(posedge clk_50MHz);
    #3;
    chk("pulse_we", 32'(ram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("pulse_rst_we", 32'(ram_we_n), 32'd1);
    chk("pulse_rst_ce", 32'(ram_ce_n), 32'd1);
    chk("pulse_rst_pause", 32'(em_PAUSE), 32'd0);
    chk("pulse_rst_op", 32'(mw_REG_op), 32'(REG_OP_NOP));
    @(negedge clk_50MHz);
    n_em_RAM_en = RAM_DISABLE;
    rst = 1'b1;
    issue(RAM_DISABLE, RAM_OP_RD, 16'h0, 16'h0, 16'h0, REG_OP_NOP, 4'd0);
    issue(RAM_DISABLE, RAM_OP_RD, 16'h0, 16'h0, 16'hA55A, 2'd2, 4'd12);
    issue(RAM_ENABLE, RAM_OP_RD, 16'h8000, 16'h0, 16'h0, 2'd3, 4'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
